// File: rtl/alu_seq_pkg.sv
// Purpose : shared opcode encodings, FSM state type and flag bit positions for alu_seq.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_NOTA   = 4'd1;
    localparam logic [3:0] OP_NOTB   = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_ADD    = 4'd6;
    localparam logic [3:0] OP_SUB    = 4'd7;
    localparam logic [3:0] OP_SHL    = 4'd8;
    localparam logic [3:0] OP_SHR    = 4'd9;
    localparam logic [3:0] OP_MUL    = 4'd10;
    localparam logic [3:0] OP_ACCADD = 4'd11;
    localparam logic [3:0] OP_ACCCLR = 4'd12;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Bit positions inside the 4-bit flags word {neg, zero, carry, ovf}.
    localparam int FLG_NEG   = 3;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Purpose : shift-add unsigned multiplier iterator, one partial product per cycle.
// Latency : WIDTH cycles after start; done is high during the last iteration cycle.
// Backpr. : none; the parent must not pulse start while an iteration is running.
// Ports   : clk, rst (sync, active-high); start with operands a/b;
//           done marks the final iteration, product/hi_nonzero are valid while done=1.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             hi_nonzero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic               running;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   b_sh;

    assign prod_nx = prod + (b_sh[0] ? a_sh : '0);

    // done/product are taken from prod_nx so the parent can capture the final
    // value on the same edge that performs the last iteration.
    assign done       = running & (count == LAST);
    assign product    = prod_nx[WIDTH-1:0];
    assign hi_nonzero = |prod_nx[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            count   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            prod    <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
            a_sh    <= {{WIDTH{1'b0}}, a};
            b_sh    <= b;
            prod    <= '0;
        end else if (running) begin
            prod  <= prod_nx;
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            count <= count + CW'(1);
            if (count == LAST) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Purpose : registered WIDTH-bit ALU with flags, accumulator and multi-cycle multiply.
// Latency : 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpr. : in_ready low while a MUL iterates or a result is held with out_ready low.
// Ports   : clk, rst (sync, active-high); in_valid/in_ready + value_a, value_b, opcode;
//           out_valid/out_ready + result, flags {neg,zero,carry,ovf}, err; acc = accumulator.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] value_a,
    input  logic [WIDTH-1:0] value_b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output logic [WIDTH-1:0] acc
);
    localparam int SHW = $clog2(WIDTH);

    state_t state;
    // Cleared by reset and set one cycle later, so in_ready stays low for
    // every cycle in which rst is sampled high.
    logic   live;

    logic accept;
    logic mul_start;
    logic mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic mul_hi_nz;

    assign in_ready  = live & (state == IDLE) & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign mul_start = accept & (opcode == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .a          (value_a),
        .b          (value_b),
        .done       (mul_done),
        .product    (mul_prod),
        .hi_nonzero (mul_hi_nz)
    );

    // Extended arithmetic: the extra top bit is carry-out / borrow.
    logic [SHW-1:0] shamt;
    logic [WIDTH:0] sum_ab;
    logic [WIDTH:0] dif_ab;
    logic [WIDTH:0] sum_acc;
    logic [WIDTH:0] shl_ext;
    logic [WIDTH:0] shr_ext;

    assign shamt   = value_b[SHW-1:0];
    assign sum_ab  = {1'b0, value_a} + {1'b0, value_b};
    assign dif_ab  = {1'b0, value_a} - {1'b0, value_b};
    assign sum_acc = {1'b0, acc} + {1'b0, value_a};
    // A zero shift leaves the guard bit at 0, which gives carry=0 for free.
    assign shl_ext = {1'b0, value_a} << shamt;
    assign shr_ext = {value_a, 1'b0} >> shamt;

    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic             err_c;
    logic [3:0]       flags_c;
    logic [3:0]       mul_flags;

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        err_c   = 1'b0;
        case (opcode)
            OP_NOP, OP_MUL, OP_ACCCLR: res_c = '0;
            OP_NOTA: res_c = ~value_a;
            OP_NOTB: res_c = ~value_b;
            OP_OR:   res_c = value_a | value_b;
            OP_AND:  res_c = value_a & value_b;
            OP_XOR:  res_c = value_a ^ value_b;
            OP_ADD: begin
                res_c   = sum_ab[WIDTH-1:0];
                carry_c = sum_ab[WIDTH];
                ovf_c   = (value_a[WIDTH-1] == value_b[WIDTH-1]) &&
                          (sum_ab[WIDTH-1] != value_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = dif_ab[WIDTH-1:0];
                carry_c = dif_ab[WIDTH];
                ovf_c   = (value_a[WIDTH-1] != value_b[WIDTH-1]) &&
                          (dif_ab[WIDTH-1] != value_a[WIDTH-1]);
            end
            OP_SHL: begin
                res_c   = shl_ext[WIDTH-1:0];
                carry_c = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_c   = shr_ext[WIDTH:1];
                carry_c = shr_ext[0];
            end
            OP_ACCADD: begin
                res_c   = sum_acc[WIDTH-1:0];
                carry_c = sum_acc[WIDTH];
                ovf_c   = (acc[WIDTH-1] == value_a[WIDTH-1]) &&
                          (sum_acc[WIDTH-1] != acc[WIDTH-1]);
            end
            default: err_c = 1'b1;
        endcase
    end

    always_comb begin
        flags_c = '0;
        if (!err_c) begin
            flags_c[FLG_NEG]   = res_c[WIDTH-1];
            flags_c[FLG_ZERO]  = (res_c == '0);
            flags_c[FLG_CARRY] = carry_c;
            flags_c[FLG_OVF]   = ovf_c;
        end
    end

    always_comb begin
        mul_flags            = '0;
        mul_flags[FLG_NEG]   = mul_prod[WIDTH-1];
        mul_flags[FLG_ZERO]  = (mul_prod == '0);
        mul_flags[FLG_CARRY] = mul_hi_nz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            live      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            err       <= 1'b0;
            acc       <= '0;
        end else begin
            live <= 1'b1;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (opcode == OP_MUL) begin
                    state <= BUSY;
                end else begin
                    result    <= res_c;
                    flags     <= flags_c;
                    err       <= err_c;
                    out_valid <= 1'b1;
                    if (opcode == OP_ACCADD) begin
                        acc <= sum_acc[WIDTH-1:0];
                    end else if (opcode == OP_ACCCLR) begin
                        acc <= '0;
                    end
                end
            end
            // out_valid is always low in BUSY (accept required a free slot).
            if (state == BUSY && mul_done) begin
                state     <= IDLE;
                result    <= mul_prod;
                flags     <= mul_flags;
                err       <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] value_a;
    logic [7:0] value_b;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic       err;
    logic [7:0] acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value_a   (value_a),
        .value_b   (value_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err),
        .acc       (acc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat at a negedge, confirm it will be accepted, drop it after the edge.
    task automatic send(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode   = op;
        value_a  = a;
        value_b  = b;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        value_a = '0; value_b = '0; opcode = '0;

        // Reset then idle
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_acc", acc, 8'h00);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", flags, 4'h0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // ADD 0x7F + 0x01 -> 0x80, neg & ovf
        send("add", 4'd6, 8'h7F, 8'h01);
        chk("add_valid", out_valid, 1'b1);
        chk("add_result", result, 8'h80);
        chk("add_flags", flags, 4'b1001);
        chk("add_err", err, 1'b0);

        // SUB 3 - 5 -> 0xFE, neg & borrow
        send("sub", 4'd7, 8'h03, 8'h05);
        chk("sub_result", result, 8'hFE);
        chk("sub_flags", flags, 4'b1010);

        // MUL 0x12 * 0x0D = 0xEA
        send("mul1", 4'd10, 8'h12, 8'h0D);
        for (int i = 1; i < 9; i++) begin
            if (i > 1) @(negedge clk);
            chk($sformatf("mul1_busy_rdy_%0d", i), in_ready, 1'b0);
            chk($sformatf("mul1_busy_vld_%0d", i), out_valid, 1'b0);
        end
        @(negedge clk);
        chk("mul1_valid", out_valid, 1'b1);
        chk("mul1_result", result, 8'hEA);
        chk("mul1_flags", flags, 4'b1000);

        // MUL 0x10 * 0x10 = 0x100 -> low 0, zero & carry; issued while previous result drains
        send("mul2", 4'd10, 8'h10, 8'h10);
        repeat (7) @(negedge clk);
        chk("mul2_busy_vld", out_valid, 1'b0);
        @(negedge clk);
        chk("mul2_valid", out_valid, 1'b1);
        chk("mul2_result", result, 8'h00);
        chk("mul2_flags", flags, 4'b0110);

        // Back-pressure: AND 0xF0 & 0x3C held while out_ready=0
        send("and", 4'd4, 8'hF0, 8'h3C);
        out_ready = 1'b0;
        opcode = 4'd3; value_a = 8'h0F; value_b = 8'hF0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_valid_%0d", i), out_valid, 1'b1);
            chk($sformatf("stall_result_%0d", i), result, 8'h30);
            chk($sformatf("stall_flags_%0d", i), flags, 4'b0000);
            chk($sformatf("stall_in_ready_%0d", i), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("or_valid", out_valid, 1'b1);
        chk("or_result", result, 8'hFF);
        chk("or_flags", flags, 4'b1000);

        // Accumulator
        send("acc1", 4'd11, 8'hF0, 8'h00);
        chk("acc1_acc", acc, 8'hF0);
        chk("acc1_result", result, 8'hF0);
        chk("acc1_flags", flags, 4'b1000);
        send("acc2", 4'd11, 8'h20, 8'h00);
        chk("acc2_acc", acc, 8'h10);
        chk("acc2_flags", flags, 4'b0010);
        send("accclr", 4'd12, 8'h55, 8'h66);
        chk("accclr_acc", acc, 8'h00);
        chk("accclr_result", result, 8'h00);
        chk("accclr_flags", flags, 4'b0100);
        send("illegal", 4'd14, 8'h12, 8'h34);
        chk("illegal_err", err, 1'b1);
        chk("illegal_result", result, 8'h00);
        chk("illegal_flags", flags, 4'b0000);

        // Reset mid-MUL: make acc nonzero first so the clear is observable
        send("acc3", 4'd11, 8'h33, 8'h00);
        chk("acc3_acc", acc, 8'h33);
        send("mul3", 4'd10, 8'h12, 8'h0D);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_acc", acc, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_valid_%0d", i), out_valid, 1'b0);
        end
        send("xor", 4'd5, 8'hAA, 8'hFF);
        chk("xor_valid", out_valid, 1'b1);
        chk("xor_result", result, 8'h55);
        chk("xor_flags", flags, 4'b0000);
        chk("xor_err", err, 1'b0);
        chk("xor_acc", acc, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
